// File: rtl/rotary_input_conditioner.sv
// rtl/rotary_input_conditioner.sv - rotary encoder front end: sync, debounce, optional step decode (ROT_STEP_DETECT_EN)
module rotary_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic rotA_raw,
    input  logic rotB_raw,
    output logic rotA,
    output logic rotB,
    output logic step_up,
    output logic step_down,
    output logic step_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             meta_a, meta_b;
    logic             s_a, s_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    // Two-flop synchroniser per contact; nothing between the stages
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            meta_a <= 1'b0;
            meta_b <= 1'b0;
            s_a    <= 1'b0;
            s_b    <= 1'b0;
        end else begin
            meta_a <= rotA_raw;
            meta_b <= rotB_raw;
            s_a    <= meta_a;
            s_b    <= meta_b;
        end
    end

    // Debounce A: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            cnt_a <= '0;
            rotA  <= 1'b0;
        end else if (s_a == rotA) begin
            cnt_a <= '0;
        end else if (cnt_a == CNT_LAST) begin
            rotA  <= s_a;
            cnt_a <= '0;
        end else begin
            cnt_a <= cnt_a + CNT_ONE;
        end
    end

    // Debounce B: same rule, fully independent of A
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            cnt_b <= '0;
            rotB  <= 1'b0;
        end else if (s_b == rotB) begin
            cnt_b <= '0;
        end else if (cnt_b == CNT_LAST) begin
            rotB  <= s_b;
            cnt_b <= '0;
        end else begin
            cnt_b <= cnt_b + CNT_ONE;
        end
    end

`ifdef ROT_STEP_DETECT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        B_FIRST = 2'd1,
        A_FIRST = 2'd2,
        DONE    = 2'd3
    } step_state_t;

    step_state_t state, state_nxt;
    logic        up_nxt, down_nxt, err_nxt;
    logic [1:0]  ab;

    assign ab = {rotA, rotB};

    // State register plus registered step pulses
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_up   <= up_nxt;
            step_down <= down_nxt;
            step_err  <= err_nxt;
        end
    end

    // Next state: track which contact moved first since the last 00 rest position
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ab == 2'b01)      state_nxt = B_FIRST;
                else if (ab == 2'b10) state_nxt = A_FIRST;
                else if (ab == 2'b11) state_nxt = DONE;
            end
            B_FIRST: begin
                if (ab == 2'b11)      state_nxt = DONE;
                else if (ab == 2'b00) state_nxt = IDLE;
                else if (ab == 2'b10) state_nxt = A_FIRST;
            end
            A_FIRST: begin
                if (ab == 2'b11)      state_nxt = DONE;
                else if (ab == 2'b00) state_nxt = IDLE;
                else if (ab == 2'b01) state_nxt = B_FIRST;
            end
            default: begin
                if (ab == 2'b00)      state_nxt = IDLE;
            end
        endcase
    end

    // Pulse decode: B-first completion is an increment, A-first a decrement, a double change is an error
    always_comb begin
        up_nxt   = 1'b0;
        down_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            IDLE:    err_nxt  = (ab == 2'b11);
            B_FIRST: begin
                up_nxt  = (ab == 2'b11);
                err_nxt = (ab == 2'b10);
            end
            A_FIRST: begin
                down_nxt = (ab == 2'b11);
                err_nxt  = (ab == 2'b01);
            end
            default: ;
        endcase
    end
`else
    assign step_up   = 1'b0;
    assign step_down = 1'b0;
    assign step_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// tb/tb_rotary_input_conditioner.sv - randomized self-checking bench for rotary_input_conditioner
module tb_rotary_input_conditioner;

    localparam int D = 4;
    localparam bit STEP_EN =
`ifdef ROT_STEP_DETECT_EN
        1'b1;
`else
        1'b0;
`endif

    logic qzt_clk = 1'b0;
    logic reset   = 1'b1;
    logic rotA_raw = 1'b1;
    logic rotB_raw = 1'b1;
    logic rotA, rotB, step_up, step_down, step_err;

    int n_checks = 0;
    int n_errors = 0;
    int up_seen, down_seen, err_seen;

    // Reference state
    bit       m_a, m_b, m_up, m_down, m_err, m_done;
    bit [1:0] m_prev;
    bit       ra_q[$], rb_q[$], sa_q[$], sb_q[$];

    rotary_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .rotA_raw (rotA_raw),
        .rotB_raw (rotB_raw),
        .rotA     (rotA),
        .rotB     (rotB),
        .step_up  (step_up),
        .step_down(step_down),
        .step_err (step_err)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A level is accepted once the synchronised input has disagreed with it D times in a row
    function automatic bit settle(input bit hist[$], input bit cur);
        int run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == cur) break;
            run++;
        end
        return (run >= D) ? ~cur : cur;
    endfunction

    task automatic model_edge(input bit a, input bit b, input bit r);
        bit [1:0] cur;
        bit       sa, sb;
        m_up = 0; m_down = 0; m_err = 0;
        if (r) begin
            ra_q.delete(); rb_q.delete(); sa_q.delete(); sb_q.delete();
            m_a = 0; m_b = 0; m_prev = 2'b00; m_done = 0;
            return;
        end
        // step decode from the debounced pair the decoder sees at this edge
        cur = {m_a, m_b};
        if (m_done) begin
            if (cur == 2'b00) m_done = 0;
        end else if (cur != m_prev) begin
            if (cur == 2'b11) begin
                m_done = 1;
                if (m_prev == 2'b01)      m_up   = 1;
                else if (m_prev == 2'b10) m_down = 1;
                else                      m_err  = 1;
            end else if (cur != 2'b00 && m_prev != 2'b00) begin
                m_err = 1;
            end
        end
        m_prev = cur;
        // synchronised level is the raw sample from two edges ago (0 right after reset)
        ra_q.push_back(a);
        rb_q.push_back(b);
        sa = (ra_q.size() >= 3) ? ra_q[ra_q.size() - 3] : 1'b0;
        sb = (rb_q.size() >= 3) ? rb_q[rb_q.size() - 3] : 1'b0;
        if (ra_q.size() > 8) begin
            void'(ra_q.pop_front());
            void'(rb_q.pop_front());
        end
        sa_q.push_back(sa);
        sb_q.push_back(sb);
        if (sa_q.size() > D) begin
            void'(sa_q.pop_front());
            void'(sb_q.pop_front());
        end
        m_a = settle(sa_q, m_a);
        m_b = settle(sb_q, m_b);
    endtask

    task automatic cycle(input bit a, input bit b, input bit r);
        rotA_raw = a;
        rotB_raw = b;
        reset    = r;
        @(posedge qzt_clk);
        model_edge(a, b, r);
        @(negedge qzt_clk);
        check("rotA", rotA, m_a);
        check("rotB", rotB, m_b);
        check("step_up",   step_up,   STEP_EN ? m_up   : 1'b0);
        check("step_down", step_down, STEP_EN ? m_down : 1'b0);
        check("step_err",  step_err,  STEP_EN ? m_err  : 1'b0);
        if (step_up + step_down + step_err > 1) check("step_onehot", 1, 0);
        up_seen   += int'(step_up);
        down_seen += int'(step_down);
        err_seen  += int'(step_err);
    endtask

    task automatic seg(input bit a, input bit b, input int len);
        for (int i = 0; i < len; i++) cycle(a, b, 1'b0);
    endtask

    task automatic clear_counts();
        up_seen = 0; down_seen = 0; err_seen = 0;
    endtask

    task automatic check_counts(input string tag, input int up, input int dn, input int er);
        check({tag, "_up"},   up_seen,   STEP_EN ? up : 0);
        check({tag, "_down"}, down_seen, STEP_EN ? dn : 0);
        check({tag, "_err"},  err_seen,  STEP_EN ? er : 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  ra, rb;
        clear_counts();
        @(negedge qzt_clk);

        // 1: reset with raw high, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
        check("t1_in_reset", {rotA, rotB, step_up, step_down, step_err}, 5'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("t1_rel1", {rotA, rotB}, 2'b00);
        seg(1'b1, 1'b1, 4);
        check("t1_rel5", {rotA, rotB}, 2'b00);
        cycle(1'b1, 1'b1, 1'b0);
        check("t1_rel6", {rotA, rotB}, 2'b11);
        seg(1'b0, 1'b0, 10);

        // 2: latency of a clean A edge
        n = 0;
        do begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end while (!rotA && n < 20);
        check("t2_latency", n, 6);
        check("t2_rotB", rotB, 0);
        seg(1'b0, 1'b0, 10);

        // 3: short pulse rejected, bounce restarts the count
        seen = 0;
        for (int i = 0; i < 3; i++) begin cycle(1'b0, 1'b1, 1'b0); seen |= rotB; end
        for (int i = 0; i < 8; i++) begin cycle(1'b0, 1'b0, 1'b0); seen |= rotB; end
        check("t3_short", seen, 0);
        seg(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            cycle(1'b0, 1'b1, 1'b0);
            n++;
        end while (!rotB && n < 20);
        check("t3_bounce", n, 6);
        seg(1'b0, 1'b0, 10);

        // 4: CW then CCW detents
        clear_counts();
        seg(1'b0, 1'b1, 10); seg(1'b1, 1'b1, 10); seg(1'b0, 1'b0, 10);
        check_counts("t4_cw", 1, 0, 0);
        clear_counts();
        seg(1'b1, 1'b0, 10); seg(1'b1, 1'b1, 10); seg(1'b0, 1'b0, 10);
        check_counts("t4_ccw", 0, 1, 0);

        // 5: both contacts change together, then no pulse until back at 00
        clear_counts();
        seg(1'b1, 1'b1, 10); seg(1'b0, 1'b1, 10); seg(1'b1, 1'b1, 10);
        check_counts("t5_illegal", 0, 0, 1);
        seg(1'b0, 1'b0, 10);

        // 6: reset in the middle of a debounce count
        seg(1'b1, 1'b0, 4);
        cycle(1'b1, 1'b0, 1'b1);
        check("t6_in_reset", rotA, 0);
        n = 0;
        do begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end while (!rotA && n < 20);
        check("t6_latency", n, 6);
        clear_counts();
        seg(1'b1, 1'b1, 10); seg(1'b0, 1'b0, 10);
        check_counts("t6_restart", 0, 1, 0);

        // Random contact activity with bounces and occasional resets
        for (int s = 0; s < 200; s++) begin
            ra = 1'($urandom);
            rb = 1'($urandom);
            if ($urandom_range(0, 39) == 0) cycle(ra, rb, 1'b1);
            seg(ra, rb, int'($urandom_range(1, 10)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
